// File: rtl/fft_tw_pkg.sv
// Shared types, default sizing and the twiddle address formula for the FFT twiddle fetch sequencer.
package fft_tw_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } tw_state_e;

    localparam int ADDR_WIDTH_DEF = 5;
    localparam int LOG2N          = ADDR_WIDTH_DEF + 1;
    localparam int NHALF          = 2 ** ADDR_WIDTH_DEF;
    localparam int STAGE_W        = $clog2(ADDR_WIDTH_DEF + 1);

    // DIF twiddle index: keep the low (ADDR_WIDTH - s) bits of j, scale by 2**s; last stage collapses to 0
    function automatic logic [31:0] tw_addr(input logic [31:0] j, input logic [31:0] s, input int aw);
        logic [31:0] mask;
        mask    = (32'd1 << (32'(aw) - s)) - 32'd1;
        tw_addr = (j & mask) << s;
    endfunction

endpackage

// File: rtl/tw_addr_gen.sv
// Butterfly/stage issue counters and ROM address generation for the twiddle fetch sequencer.
module tw_addr_gen #(
    parameter int ADDR_WIDTH = 5,
    localparam int STAGE_W   = $clog2(ADDR_WIDTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  advance,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [STAGE_W-1:0]    stage,
    output logic                  last,
    output logic                  fin
);
    import fft_tw_pkg::*;

    localparam int LOG2N_L = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] j_r;
    logic [STAGE_W-1:0]    s_r;
    logic                  last_s;
    logic                  fin_s;

    assign last_s = (j_r == {ADDR_WIDTH{1'b1}});
    assign fin_s  = last_s && (s_r == STAGE_W'(LOG2N_L - 1));

    // Counters return to stage 0 after the final issue so an idle sequencer presents address 0
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            j_r <= {ADDR_WIDTH{1'b0}};
            s_r <= {STAGE_W{1'b0}};
        end else if (advance) begin
            j_r <= j_r + ADDR_WIDTH'(1);
            if (fin_s) begin
                s_r <= {STAGE_W{1'b0}};
            end else if (last_s) begin
                s_r <= s_r + STAGE_W'(1);
            end
        end
    end

    assign addr  = ADDR_WIDTH'(tw_addr(32'(j_r), 32'(s_r), ADDR_WIDTH));
    assign stage = s_r;
    assign last  = last_s;
    assign fin   = fin_s;

endmodule

// File: rtl/twiddle_fetch_sequencer.sv
// Streams the twiddles of one radix-2 DIF FFT from a sync ROM; the ROM output register is the output stage.
// Optional IFFT_CONJ_EN adds an inverse input that conjugates every twiddle of the run.
module twiddle_fetch_sequencer #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    localparam int STAGE_W   = $clog2(ADDR_WIDTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
`ifdef IFFT_CONJ_EN
    input  logic                  inverse,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  rom_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_dout,
    output logic                  tw_valid,
    input  logic                  tw_ready,
    output logic [DATA_WIDTH-1:0] tw_data,
    output logic [STAGE_W-1:0]    tw_stage,
    output logic                  tw_last,
    output logic                  tw_end
);
    import fft_tw_pkg::*;

    localparam int HALF_W = DATA_WIDTH / 2;

    tw_state_e          state_r;
    logic               busy_r;
    logic               done_r;
    logic               tw_valid_r;
    logic [STAGE_W-1:0] tw_stage_r;
    logic               tw_last_r;
    logic               tw_end_r;
    logic               rom_en_s;
    logic [STAGE_W-1:0] stage_s;
    logic               last_s;
    logic               fin_s;

    // A new ROM read is issued only when the output register is empty or being drained this cycle
    assign rom_en_s = (state_r == RUN) && (!tw_valid_r || tw_ready);

    tw_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clock   (clock),
        .reset_n (reset_n),
        .advance (rom_en_s),
        .addr    (rom_addr),
        .stage   (stage_s),
        .last    (last_s),
        .fin     (fin_s)
    );

    // Run control: IDLE -> RUN until the final issue, DRAIN until the final beat is taken
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r <= RUN;
                        busy_r  <= 1'b1;
                    end
                end
                RUN: begin
                    if (rom_en_s && fin_s) begin
                        state_r <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (tw_valid_r && tw_ready) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Sideband travels with the ROM read so it stays aligned with rom_dout through stalls
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tw_valid_r <= 1'b0;
            tw_stage_r <= {STAGE_W{1'b0}};
            tw_last_r  <= 1'b0;
            tw_end_r   <= 1'b0;
        end else if (rom_en_s) begin
            tw_valid_r <= 1'b1;
            tw_stage_r <= stage_s;
            tw_last_r  <= last_s;
            tw_end_r   <= fin_s;
        end else if (tw_ready) begin
            tw_valid_r <= 1'b0;
        end
    end

`ifdef IFFT_CONJ_EN
    logic              inv_r;
    logic [HALF_W-1:0] im_neg_s;

    // Conjugate mode is captured once per run
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inv_r <= 1'b0;
        end else if ((state_r == IDLE) && start) begin
            inv_r <= inverse;
        end
    end

    assign im_neg_s = ~rom_dout[HALF_W-1:0] + HALF_W'(1);
    assign tw_data  = inv_r ? {rom_dout[DATA_WIDTH-1:HALF_W], im_neg_s} : rom_dout;
`else
    assign tw_data  = rom_dout;
`endif

    assign busy     = busy_r;
    assign done     = done_r;
    assign rom_en   = rom_en_s;
    assign tw_valid = tw_valid_r;
    assign tw_stage = tw_stage_r;
    assign tw_last  = tw_last_r;
    assign tw_end   = tw_end_r;

endmodule
